multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state controller that sequences the shared datapath (register file, ALU, sign extender, unified instruction/data memory) as a multi-cycle MIPS processor. It decodes the opcode latched in the instruction register and drives every datapath select and write-enable, one state per cycle. Memory accesses wait on a ready handshake. The block replaces the single-cycle `control` path when the memory is shared and may insert wait states.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `opcode` in 6: instruction register bits [31:26].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: unconditional PC load.
- `pc_write_cond` out 1: PC load if `zero`.
- `iord` out 1: memory address select, 0=PC, 1=ALUOut.
- `mem_read` out 1: memory read request.
- `mem_write` out 1: memory write request.
- `ir_write` out 1: instruction register load.
- `mem_to_reg` out 1: write-back data select, 0=ALUOut, 1=MDR.
- `reg_dst` out 1: write register select, 0=rt, 1=rd.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 1: 0=PC, 1=A.
- `alu_src_b` out 2: 00=B, 01=4, 10=sign-extended immediate, 11=sign-extended immediate<<2.
- `alu_op` out 2: 00=add, 01=sub, 10=funct-decoded, to `AluControl`.
- `pc_source` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 are unreachable; if entered, the next state is FETCH.
- Outputs are decoded from state. Any output not listed for a state is 0.
- FETCH:
  - `mem_read`=1, `alu_src_b`=01.
  - `ir_write` and `pc_write` = `mem_ready` (Mealy).
  - Stays in FETCH until `mem_ready`=1, then goes to DECODE.
- DECODE: `alu_src_b`=11 (branch target precompute). Next state by opcode:
  - 000000 → EXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BRANCH
  - 001000 → ADDIEX
  - 000010 → JUMP (see Configuration)
  - any other opcode: `illegal`=1 this cycle, next state FETCH. The PC has already advanced by 4.
- MEMADR: `alu_src_a`=1, `alu_src_b`=10. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_read`=1, `iord`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `reg_write`=1, `mem_to_reg`=1. Next state FETCH.
- MEMWR: `mem_write`=1, `iord`=1. Holds until `mem_ready`, then goes to FETCH.
- EXEC: `alu_src_a`=1, `alu_op`=10. Next state ALUWB.
- ALUWB: `reg_write`=1, `reg_dst`=1. Next state FETCH.
- BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Next state FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10. Next state ADDIWB.
- ADDIWB: `reg_write`=1. Next state FETCH.
- JUMP: `pc_write`=1, `pc_source`=10. Next state FETCH.
- `mem_read` and `mem_write` are never asserted together.
- `mem_read` or `mem_write` stays asserted, with `iord` stable, for the whole wait.
- `opcode` is sampled only in DECODE and MEMADR.

## Timing
- Reset:
  - While `rst_n`=0, all outputs are forced to 0 and `state` reads 0.
  - The state register loads FETCH at every rising edge with `rst_n`=0.
  - The first fetch request is asserted in the first cycle after `rst_n` rises.
  - Reset asserted mid-instruction, including during a memory wait, aborts it at the next edge. No write-enable is asserted in the reset cycle.
- Instruction latency with `mem_ready` held at 1:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - addi: 4 cycles
  - j: 3 cycles
  - illegal opcode: 2 cycles
- Each cycle with `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` has no effect in any other state.

## Configuration
- `MC_JUMP_EN` defined: opcode 000010 goes DECODE→JUMP.
- `MC_JUMP_EN` undefined:
  - opcode 000010 is illegal: `illegal` pulses in DECODE and the next state is FETCH.
  - State 11 is unreachable and treated like codes 12–15.
  - `pc_source` never takes the value 10.

## Test plan
- Reset: `rst_n`=0 for 3 cycles with `mem_ready`=1 → all outputs 0. After release: `state`=0, `mem_read`=1, `ir_write`=1, `pc_write`=1.
- lw (opcode 100011) with `mem_ready` low for 2 cycles in MEMRD:
  - `state` sequence is 0,1,2,3,3,3,4,0.
  - `reg_write`=1 and `mem_to_reg`=1 only in state 4.
- beq (000100) with `zero`=1:
  - `state` sequence is 0,1,8,0.
  - `pc_write_cond`=1, `alu_op`=01, `pc_source`=01 in state 8.
- R-type then addi (001000):
  - `state` sequence is 0,1,6,7,0,1,9,10,0.
  - `reg_dst`=1 in state 7; `reg_dst`=0 in state 10.
- Opcode 111111 → `illegal`=1 for exactly one cycle in state 1, then state 0. Opcode 000010 → state 11 with `MC_JUMP_EN` defined; `illegal` pulse without it.
- `rst_n` dropped during a MEMWR wait → `mem_write` falls to 0 the same cycle, and `state`=0 after the edge.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multi-cycle MIPS controller and its shared datapath.
// The controller (master) consumes opcode/zero/mem_ready and drives every select and enable.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
               pc_source, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: one state per cycle, memory states wait on mem_ready.
// Optional feature macro: MC_JUMP_EN (enables the j instruction / JUMP state).
module multicycle_control (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_JUMP_EN
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
`ifdef MC_JUMP_EN
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
`endif

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;

    // zero gates pc_write_cond inside the datapath; the controller never needs it.
    logic unused_zero;
    assign unused_zero = bus.zero;

    // NOTE: synchronous reset -- rst_n is only sampled at the rising edge, and
    // sequential state is always updated with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_d = FETCH;
        ctrl    = '0;

        case (state_q)
            FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
                state_d        = bus.mem_ready ? DECODE : FETCH;
            end

            DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                case (bus.opcode)
                    OP_RTYPE:     state_d = EXEC;
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = JUMP;
`endif
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_d      = FETCH;
                    end
                endcase
            end

            MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (bus.opcode == OP_SW) ? MEMWR : MEMRD;
            end

            MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
                state_d       = bus.mem_ready ? MEMWB : MEMRD;
            end

            MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = FETCH;
            end

            MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                state_d        = bus.mem_ready ? FETCH : MEMWR;
            end

            EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNC;
                state_d        = ALUWB;
            end

            ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                state_d        = FETCH;
            end

            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_OUT;
                state_d            = FETCH;
            end

            ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = ADDIWB;
            end

            ADDIWB: begin
                ctrl.reg_write = 1'b1;
                state_d        = FETCH;
            end

`ifdef MC_JUMP_EN
            JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JMP;
                state_d        = FETCH;
            end
`endif

            // Unreachable encodings (and JUMP when jumps are disabled) recover to FETCH.
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // Reset gates the outputs combinationally so an aborted access drops at once.
    assign ctrl_out = rst_n ? ctrl : '0;

    assign bus.pc_write      = ctrl_out.pc_write;
    assign bus.pc_write_cond = ctrl_out.pc_write_cond;
    assign bus.iord          = ctrl_out.iord;
    assign bus.mem_read      = ctrl_out.mem_read;
    assign bus.mem_write     = ctrl_out.mem_write;
    assign bus.ir_write      = ctrl_out.ir_write;
    assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
    assign bus.reg_dst       = ctrl_out.reg_dst;
    assign bus.reg_write     = ctrl_out.reg_write;
    assign bus.alu_src_a     = ctrl_out.alu_src_a;
    assign bus.alu_src_b     = ctrl_out.alu_src_b;
    assign bus.alu_op        = ctrl_out.alu_op;
    assign bus.pc_source     = ctrl_out.pc_source;
    assign bus.illegal       = ctrl_out.illegal;
    assign bus.state         = rst_n ? state_q : FETCH;

    a_mem_exclusive : assert property (@(posedge clk) !(bus.mem_read && bus.mem_write));

`ifndef MC_JUMP_EN
    a_no_jump_source : assert property (@(posedge clk) bus.pc_source != 2'b10);
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a randomized
// instruction stream compared cycle by cycle against a per-instruction state/output model.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One expected cycle: state, control vector, and the inputs to drive that cycle.
    typedef struct packed {
        logic [3:0]  st;
        logic [16:0] ctl;
        logic        rdy;
        logic [5:0]  opc;
    } step_t;

    step_t exp_q[$];

    function automatic logic [16:0] mk(input logic pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa,
                                       input logic [1:0] asb, aop, psrc, input logic ill);
        return {pw, pwc, io, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    function automatic logic [16:0] obs_ctl();
        return {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, bus.illegal};
    endfunction

    function automatic logic [5:0] rnd_opc();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [3:0] st, input logic [16:0] ctl, input logic rdy,
                        input logic [5:0] opc);
        step_t s;
        s.st  = st;
        s.ctl = ctl;
        s.rdy = rdy;
        s.opc = opc;
        exp_q.push_back(s);
    endtask

    // A fetch that is still waiting for memory.
    task automatic push_fetch_wait();
        push(4'd0, mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b0, rnd_opc());
    endtask

    // Expected cycle list for one instruction, from its class and the wait counts.
    task automatic model_instr(input logic [5:0] o, input int fetch_waits, input int mem_waits);
        bool_class(o, fetch_waits, mem_waits);
    endtask

    task automatic bool_class(input logic [5:0] o, input int fw, input int mw);
        logic jump_ok;
`ifdef MC_JUMP_EN
        jump_ok = 1'b1;
`else
        jump_ok = 1'b0;
`endif
        for (int i = 0; i < fw; i++) push_fetch_wait();
        push(4'd0, mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, rnd_opc());

        if (o == 6'b000000) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd6, mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0), rnd_bit(), rnd_opc());
            push(4'd7, mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0), rnd_bit(), rnd_opc());
        end else if (o == 6'b100011) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd_bit(), o);
            for (int i = 0; i < mw; i++)
                push(4'd3, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rnd_opc());
            push(4'd3, mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rnd_opc());
            push(4'd4, mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0), rnd_bit(), rnd_opc());
        end else if (o == 6'b101011) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd2, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd_bit(), o);
            for (int i = 0; i < mw; i++)
                push(4'd5, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, rnd_opc());
            push(4'd5, mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b1, rnd_opc());
        end else if (o == 6'b000100) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd8, mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0), rnd_bit(), rnd_opc());
        end else if (o == 6'b001000) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd9, mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), rnd_bit(), rnd_opc());
            push(4'd10, mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0), rnd_bit(), rnd_opc());
        end else if (o == 6'b000010 && jump_ok) begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), rnd_bit(), o);
            push(4'd11, mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0), rnd_bit(), rnd_opc());
        end else begin
            push(4'd1, mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1), rnd_bit(), o);
        end
    endtask

    // Drive and check up to max_steps queued cycles (inputs at negedge, sample 1ns later).
    task automatic run_expected(input string name, input int max_steps);
        step_t s;
        int    n;
        n = 0;
        while (exp_q.size() > 0 && n < max_steps) begin
            s = exp_q.pop_front();
            @(negedge clk);
            bus.mem_ready = s.rdy;
            bus.opcode    = s.opc;
            bus.zero      = rnd_bit();
            #1;
            checks++;
            if (bus.state !== s.st) begin
                errors++;
                $display("FAIL %s step %0d state: got %0d expected %0d", name, n, bus.state, s.st);
            end
            checks++;
            if (obs_ctl() !== s.ctl) begin
                errors++;
                $display("FAIL %s step %0d ctl(state %0d): got %b expected %b",
                         name, n, s.st, obs_ctl(), s.ctl);
            end
            n++;
        end
        exp_q.delete();
    endtask

    // Hold reset across two edges, release just after an edge: next cycle is FETCH.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b100011;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs_ctl() !== 17'd0 || bus.state !== 4'd0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got state %0d ctl %b expected state 0 ctl 0",
                         i, bus.state, obs_ctl());
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.mem_read !== 1'b1 || bus.ir_write !== 1'b1 ||
            bus.pc_write !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got state %0d mr %b irw %b pcw %b expected 0 1 1 1",
                     bus.state, bus.mem_read, bus.ir_write, bus.pc_write);
        end
    endtask

    task automatic test_lw_wait();
        do_reset();
        model_instr(6'b100011, 0, 2);
        push_fetch_wait();
        run_expected("lw_wait", 100);
    endtask

    task automatic test_beq();
        do_reset();
        model_instr(6'b000100, 0, 0);
        push_fetch_wait();
        run_expected("beq", 100);
    endtask

    task automatic test_back_to_back();
        do_reset();
        model_instr(6'b000000, 0, 0);
        model_instr(6'b001000, 0, 0);
        push_fetch_wait();
        run_expected("rtype_addi", 100);
    endtask

    task automatic test_illegal();
        do_reset();
        model_instr(6'b111111, 1, 0);
        model_instr(6'b000010, 0, 0);
        push_fetch_wait();
        run_expected("illegal_jump", 100);
    endtask

    task automatic test_reset_in_memwr();
        do_reset();
        model_instr(6'b101011, 0, 5);
        run_expected("sw_pre_abort", 4);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.mem_write !== 1'b0 || obs_ctl() !== 17'd0 || bus.state !== 4'd0) begin
            errors++;
            $display("FAIL abort_same_cycle: got mw %b ctl %b state %0d expected 0 0 0",
                     bus.mem_write, obs_ctl(), bus.state);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || obs_ctl() !== mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0)) begin
            errors++;
            $display("FAIL abort_after_edge: got state %0d ctl %b expected FETCH wait",
                     bus.state, obs_ctl());
        end
    endtask

    task automatic test_random();
        logic [5:0] o;
        do_reset();
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(0, 7))
                0:       o = 6'b000000;
                1:       o = 6'b100011;
                2:       o = 6'b101011;
                3:       o = 6'b000100;
                4:       o = 6'b001000;
                5:       o = 6'b000010;
                default: o = rnd_opc();
            endcase
            model_instr(o, $urandom_range(0, 3), $urandom_range(0, 3));
            run_expected("random", 100);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        test_reset();
        test_lw_wait();
        test_beq();
        test_back_to_back();
        test_illegal();
        test_reset_in_memwr();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
